// File: rtl/fir_mac_scheduler.sv
// Round-robin scheduler sharing one FIR MAC engine between NUM_CH decimated streams.
// Sequences per-tap coefficient index and ring-buffer read address plus accumulator strobes.

module fir_req_slot #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              take,
  input  logic              ov_clr,
  output logic              pending,
  output logic [ADDR_W-1:0] base,
  output logic              overrun
);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= 1'b0;
      base    <= '0;
      overrun <= 1'b0;
    end else begin
      if (req) begin
        pending <= 1'b1;
        base    <= waddr;
      end else if (take) begin
        pending <= 1'b0;
      end
      // a re-request in the grant cycle refills the slot, it does not overwrite it
      if (req && pending && !take) overrun <= 1'b1;
      else if (ov_clr)             overrun <= 1'b0;
    end
  end
endmodule

module fir_mac_scheduler #(
  parameter int NUM_CH   = 2,
  parameter int NUM_TAPS = 191,
  parameter int ADDR_W   = 8,
  parameter int MAC_LAT  = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH*ADDR_W-1:0] req_waddr,
  output logic                     busy,
  output logic [1:0]               grant_ch,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [8:0]               coef_idx,
  output logic                     mac_clear,
  output logic                     mac_en,
  output logic                     mac_last,
  output logic                     acc_capture,
  output logic [NUM_CH-1:0]        overrun,
  input  logic                     overrun_clr
);
  if (NUM_TAPS < 1 || NUM_TAPS > (1 << ADDR_W) || NUM_TAPS > 512) begin : g_bad_taps
    $error("fir_mac_scheduler: NUM_TAPS out of range");
  end
  if (NUM_CH < 2 || NUM_CH > 4) begin : g_bad_ch
    $error("fir_mac_scheduler: NUM_CH must be 2..4");
  end
  if (MAC_LAT < 0 || MAC_LAT > 7) begin : g_bad_lat
    $error("fir_mac_scheduler: MAC_LAT must be 0..7");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [8:0]        LAST = 9'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0] BACK = ADDR_W'(NUM_TAPS - 1);

  state_t                         state;
  logic [1:0]                     rr_ptr;
  logic [2:0]                     drain_cnt;
  logic [NUM_CH-1:0]              pending, take;
  logic [NUM_CH-1:0][ADDR_W-1:0]  base;
  logic                           any_pend;
  logic [1:0]                     pick;
  logic [ADDR_W-1:0]              pick_base;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    assign take[c] = (state == IDLE) && any_pend && (pick == 2'(c));
    fir_req_slot #(.ADDR_W(ADDR_W)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req[c]),
      .waddr   (req_waddr[c*ADDR_W +: ADDR_W]),
      .take    (take[c]),
      .ov_clr  (overrun_clr),
      .pending (pending[c]),
      .base    (base[c]),
      .overrun (overrun[c])
    );
  end

  // lowest pending channel at/after the pointer, else lowest overall (wrap)
  always_comb begin
    any_pend  = 1'b0;
    pick      = 2'd0;
    pick_base = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_pend && pending[i] && i >= int'(rr_ptr)) begin
        any_pend  = 1'b1;
        pick      = 2'(i);
        pick_base = base[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any_pend && pending[i]) begin
        any_pend  = 1'b1;
        pick      = 2'(i);
        pick_base = base[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= 2'd0;
      drain_cnt   <= 3'd0;
      busy        <= 1'b0;
      grant_ch    <= 2'd0;
      rd_addr     <= '0;
      coef_idx    <= 9'd0;
      mac_clear   <= 1'b0;
      mac_en      <= 1'b0;
      mac_last    <= 1'b0;
      acc_capture <= 1'b0;
    end else begin
      acc_capture <= 1'b0;
      case (state)
        IDLE: if (any_pend) begin
          state     <= RUN;
          busy      <= 1'b1;
          grant_ch  <= pick;
          rr_ptr    <= (pick == 2'(NUM_CH - 1)) ? 2'd0 : pick + 2'd1;
          rd_addr   <= pick_base - BACK;
          coef_idx  <= 9'd0;
          mac_en    <= 1'b1;
          mac_clear <= 1'b1;
          mac_last  <= (NUM_TAPS == 1);
        end
        RUN: if (mac_last) begin
          mac_en    <= 1'b0;
          mac_clear <= 1'b0;
          mac_last  <= 1'b0;
          if (MAC_LAT == 0) begin
            state       <= DONE;
            acc_capture <= 1'b1;
          end else begin
            state     <= DRAIN;
            drain_cnt <= 3'd0;
          end
        end else begin
          rd_addr   <= rd_addr + 1'b1;
          coef_idx  <= coef_idx + 9'd1;
          mac_clear <= 1'b0;
          mac_last  <= (coef_idx + 9'd1 == LAST);
        end
        DRAIN: if (drain_cnt == 3'(MAC_LAT - 1)) begin
          state       <= DONE;
          acc_capture <= 1'b1;
        end else begin
          drain_cnt <= drain_cnt + 3'd1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: timeline model compared every cycle plus literal pins.
module tb_fir_mac_scheduler;
  localparam int NC = 2, NT = 191, AW = 8, ML = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, overrun_clr;
  logic [NC-1:0]     req, req6;
  logic [NC*AW-1:0]  req_waddr, waddr6;
  logic              busy, mac_clear, mac_en, mac_last, acc_capture;
  logic [1:0]        grant_ch;
  logic [AW-1:0]     rd_addr;
  logic [8:0]        coef_idx;
  logic [NC-1:0]     overrun;
  logic              busy6, clear6, en6, last6, acc6;
  logic [1:0]        grant6;
  logic [AW-1:0]     rd6;
  logic [8:0]        coef6;
  logic [NC-1:0]     ov6;

  fir_mac_scheduler #(.NUM_CH(NC), .NUM_TAPS(NT), .ADDR_W(AW), .MAC_LAT(ML)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_waddr(req_waddr),
    .busy(busy), .grant_ch(grant_ch), .rd_addr(rd_addr), .coef_idx(coef_idx),
    .mac_clear(mac_clear), .mac_en(mac_en), .mac_last(mac_last),
    .acc_capture(acc_capture), .overrun(overrun), .overrun_clr(overrun_clr));

  fir_mac_scheduler #(.NUM_CH(NC), .NUM_TAPS(1), .ADDR_W(AW), .MAC_LAT(0)) dut6 (
    .clk(clk), .reset_n(reset_n), .req(req6), .req_waddr(waddr6),
    .busy(busy6), .grant_ch(grant6), .rd_addr(rd6), .coef_idx(coef6),
    .mac_clear(clear6), .mac_en(en6), .mac_last(last6),
    .acc_capture(acc6), .overrun(ov6), .overrun_clr(overrun_clr));

  int checks = 0, errors = 0;
  int cyc = 0, c0 = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Model: pending/base per channel plus the timeline of the one job in flight.
  bit m_ok = 0, has_job = 0;
  bit pend[NC], mov[NC];
  int mbase[NC];
  int mptr = 0, t0 = 0, jch = 0, jbase = 0;

  always @(posedge clk) begin
    int t, c;
    bit found;
    t = cyc;
    if (!reset_n) begin
      m_ok = 1; has_job = 0; mptr = 0;
      for (int k = 0; k < NC; k++) begin pend[k] = 0; mov[k] = 0; mbase[k] = 0; end
    end else begin
      // engine is free once the capture cycle of the previous job has passed
      if (!has_job || t > t0 + NT + ML) begin
        found = 0;
        for (int k = 0; k < NC; k++) begin
          c = (mptr + k) % NC;
          if (!found && pend[c]) begin
            found = 1; has_job = 1; t0 = t + 1; jch = c; jbase = mbase[c];
            pend[c] = 0; mptr = (c + 1) % NC;
          end
        end
      end
      if (overrun_clr) for (int k = 0; k < NC; k++) mov[k] = 0;
      for (int k = 0; k < NC; k++)
        if (req[k]) begin
          if (pend[k]) mov[k] = 1;
          pend[k] = 1;
          mbase[k] = int'(req_waddr[k*AW +: AW]);
        end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    int o, tap;
    if (m_ok) begin
      o   = has_job ? cyc - t0 : NT + ML + 1;
      tap = (o < NT) ? o : NT - 1;
      chk("busy",        int'(busy),        int'(has_job && o <= NT + ML));
      chk("mac_en",      int'(mac_en),      int'(has_job && o < NT));
      chk("mac_clear",   int'(mac_clear),   int'(has_job && o == 0));
      chk("mac_last",    int'(mac_last),    int'(has_job && o == NT - 1));
      chk("acc_capture", int'(acc_capture), int'(has_job && o == NT + ML));
      chk("grant_ch",    int'(grant_ch),    has_job ? jch : 0);
      chk("coef_idx",    int'(coef_idx),    has_job ? tap : 0);
      chk("rd_addr",     int'(rd_addr),     has_job ? (jbase + 256 - (NT - 1) + tap) % 256 : 0);
      chk("overrun",     int'(overrun),     int'(mov[1]) * 2 + int'(mov[0]));
    end
  end

  task automatic at(int n);
    while (cyc < c0 + n) @(negedge clk);
  endtask

  initial begin
    reset_n = 0; req = '0; req_waddr = '0; overrun_clr = 0; req6 = '0; waddr6 = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst mac_en", int'(mac_en), 0);
    chk("rst overrun", int'(overrun), 0);
    chk("rst rd_addr", int'(rd_addr), 0);
    reset_n = 1;
    @(negedge clk);

    // single job, channel 0, waddr 10
    c0 = cyc; req = 2'b01; req_waddr = {8'd0, 8'd10};
    at(1);   req = '0;
    at(2);   chk("t1 en", int'(mac_en), 1); chk("t1 rd0", int'(rd_addr), 76);
             chk("t1 clear", int'(mac_clear), 1); chk("t1 coef0", int'(coef_idx), 0);
    at(3);   chk("t1 clear off", int'(mac_clear), 0);
    at(181); chk("t1 rd179", int'(rd_addr), 255);
    at(182); chk("t1 rd180", int'(rd_addr), 0);
    at(192); chk("t1 rd190", int'(rd_addr), 10); chk("t1 last", int'(mac_last), 1);
             chk("t1 coef190", int'(coef_idx), 190);
    at(193); chk("t1 en off", int'(mac_en), 0);
    at(195); chk("t1 cap", int'(acc_capture), 1); chk("t1 grant", int'(grant_ch), 0);
    at(196); chk("t1 cap off", int'(acc_capture), 0); chk("t1 idle", int'(busy), 0);

    // tie with pointer at 1: channel 1 first
    at(200); c0 = cyc; req = 2'b11; req_waddr = {8'd30, 8'd20};
    at(1);   req = '0;
    at(2);   chk("tie1 grant", int'(grant_ch), 1); chk("tie1 rd", int'(rd_addr), 96);
    at(197); chk("tie1 second", int'(grant_ch), 0); chk("tie1 rd2", int'(rd_addr), 86);
    at(400); reset_n = 0;
    at(401); reset_n = 1;

    // tie at reset pointer: channel 0 then 1, 195 cycles apart
    at(403); c0 = cyc; req = 2'b11; req_waddr = {8'd200, 8'd100};
    at(1);   req = '0;
    at(2);   chk("t2 grant0", int'(grant_ch), 0); chk("t2 rd", int'(rd_addr), 166);
    at(196); chk("t2 gap en", int'(mac_en), 0);
    at(197); chk("t2 grant1", int'(grant_ch), 1); chk("t2 clear", int'(mac_clear), 1);
             chk("t2 rd wrap", int'(rd_addr), 10);
    at(390); chk("t2 cap", int'(acc_capture), 1);

    // overrun on channel 1, newest base wins
    at(395); c0 = cyc; req = 2'b10; req_waddr = {8'd5, 8'd0};
    at(1);   req = '0;
    at(5);   req = 2'b10; req_waddr = {8'd7, 8'd0};
    at(6);   req = '0;
    at(10);  req = 2'b10; req_waddr = {8'd9, 8'd0};
    at(11);  req = '0; chk("t3 ov set", int'(overrun), 2);
    at(12);  overrun_clr = 1;
    at(13);  overrun_clr = 0; chk("t3 ov clr", int'(overrun), 0);
    at(20);  req = 2'b10; overrun_clr = 1;
    at(21);  req = '0; overrun_clr = 0; chk("t3 set wins", int'(overrun), 2);
    at(22);  overrun_clr = 1;
    at(23);  overrun_clr = 0; chk("t3 ov clr2", int'(overrun), 0);
    at(192); chk("t3 job1 last rd", int'(rd_addr), 5);
    at(387); chk("t3 job2 last", int'(mac_last), 1); chk("t3 job2 rd", int'(rd_addr), 9);

    // re-request in the grant cycle
    at(392); c0 = cyc; req = 2'b01; req_waddr = {8'd0, 8'd50};
    at(2);   req = '0; chk("t4 no ov", int'(overrun), 0);
    at(195); chk("t4 cap", int'(acc_capture), 1);
    at(196); chk("t4 idle gap", int'(busy), 0);
    at(197); chk("t4 second", int'(mac_clear), 1); chk("t4 ov", int'(overrun), 0);

    // reset mid-run at cnt 50, with channel 1 pending
    at(392); c0 = cyc; req = 2'b01; req_waddr = {8'd0, 8'd100};
    at(1);   req = '0;
    at(10);  req = 2'b10; req_waddr = {8'd3, 8'd100};
    at(11);  req = '0;
    at(52);  chk("t5 cnt50", int'(coef_idx), 50); reset_n = 0;
    at(53);  reset_n = 1; chk("t5 busy", int'(busy), 0); chk("t5 en", int'(mac_en), 0);
             chk("t5 coef", int'(coef_idx), 0);
    at(300); chk("t5 stays idle", int'(busy), 0);

    // one tap, no latency
    c0 = cyc; req6 = 2'b01; waddr6 = {8'd0, 8'd42};
    at(1);   req6 = '0;
    at(2);   chk("t6 en", int'(en6), 1); chk("t6 clear", int'(clear6), 1);
             chk("t6 last", int'(last6), 1); chk("t6 rd", int'(rd6), 42);
    at(3);   chk("t6 cap", int'(acc6), 1); chk("t6 en off", int'(en6), 0);
    at(4);   chk("t6 cap off", int'(acc6), 0); chk("t6 idle", int'(busy6), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
